mem_wb_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle memory/writeback stage for the RV32I core. It owns a word-organised data RAM with synchronous read and byte-lane writes, and applies load sign/zero extension. It adds a valid/ready request and response handshake, tag pass-through and fault detection for misaligned, out-of-range and illegal accesses. It sits between EX/MEM and the register-file writeback in the pipelined core.

---
 rtl/mem_wb_pipe.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: pipelined memory/writeback stage for the RV32I core.
// Word-organised data RAM (synchronous read, byte-lane writes), load
// sign/zero extension, request/response handshakes, tag pass-through and
// fault detection for misaligned, out-of-range and illegal accesses.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds valid and its payload
// stable until the transfer; ready never depends combinationally on the
// valid of the same channel. req_ready is a function of pipeline state and
// resp_ready only; resp_valid and the response payload come from registers
// and stay stable while resp_valid && !resp_ready.
module mem_wb_pipe #(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TAG_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [1:0]        ram_w_op,
    input  logic [31:0]       ram_wdin,
    input  logic [2:0]        mem_ext_op,
    input  logic [TAG_W-1:0]  req_tag,
    // response channel
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       mem_dout,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_is_store,
    output logic              resp_fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // load extension opcodes
    localparam logic [2:0] EXT_LB  = 3'b000;
    localparam logic [2:0] EXT_LH  = 3'b001;
    localparam logic [2:0] EXT_LW  = 3'b010;
    localparam logic [2:0] EXT_LBU = 3'b100;
    localparam logic [2:0] EXT_LHU = 3'b101;

    // access sizes (shared encoding of ram_w_op and mem_ext_op[1:0])
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // ------------------------------------------------------------------
    // pipeline state
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [TAG_W-1:0]  r_s1_tag;
    logic              r_s1_we;
    logic [2:0]        r_s1_ext;
    logic [1:0]        r_s1_off;
    logic              r_s1_fault;
    logic [31:0]       r_rdata;

    logic              r_resp_valid;
    logic [31:0]       r_dout;
    logic [TAG_W-1:0]  r_resp_tag;
    logic              r_resp_is_store;
    logic              r_resp_fault;

    logic [31:0]       r_mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // advance / accept
    // ------------------------------------------------------------------
    logic w_adv2;
    logic w_adv1;
    logic w_accept;

    assign w_adv2    = !r_resp_valid || resp_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign w_accept  = req_valid && w_adv1;
    assign req_ready = w_adv1;

    // ------------------------------------------------------------------
    // address decode
    // ------------------------------------------------------------------
    logic              w_below;
    logic [ADDR_W-1:0] w_off;
    logic              w_oor_hi;
    logic [IDX_W-1:0]  w_idx;

    // The borrow of the subtraction flags addresses below the RAM window.
    assign {w_below, w_off} = {1'b0, adr} - {1'b0, BASE_ADDR};

    // Any offset bit above the word index means the index is >= DEPTH_WORDS.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_hi_bits
            assign w_oor_hi = |w_off[ADDR_W-1:IDX_W+2];
        end else begin : g_no_hi_bits
            assign w_oor_hi = 1'b0;
        end
    endgenerate

    assign w_idx = w_off[IDX_W+1:2];

    // BASE_ADDR is word-aligned, so w_off[1:0] equals adr[1:0].
    logic [1:0] w_lane;
    assign w_lane = w_off[1:0];

    // ------------------------------------------------------------------
    // fault detection
    // ------------------------------------------------------------------
    logic [1:0] w_size;
    logic       w_op_ill;
    logic       w_misalign;
    logic       w_fault;

    // Pick the access size from the store or load opcode and flag illegal opcodes.
    always_comb begin
        w_size   = SZ_BYTE;
        w_op_ill = 1'b0;
        if (req_we) begin
            w_size   = ram_w_op;
            w_op_ill = (ram_w_op == 2'b11);
        end else begin
            w_size   = mem_ext_op[1:0];
            // legal: 000, 001, 010, 100, 101
            w_op_ill = (mem_ext_op[1:0] == 2'b11) ||
                       (mem_ext_op[2] && mem_ext_op[1]);
        end
    end

    // Halves need an even address, words a multiple of four.
    always_comb begin
        w_misalign = 1'b0;
        case (w_size)
            SZ_HALF: w_misalign = w_lane[0];
            SZ_WORD: w_misalign = (w_lane != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_fault = w_below || w_oor_hi || w_op_ill || w_misalign;

    // ------------------------------------------------------------------
    // store lane steering
    // ------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_ram_we;

    // Replicate store data across lanes and enable only the addressed ones.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = ram_wdin;
        case (ram_w_op)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{ram_wdin[7:0]}};
            end
            SZ_HALF: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ram_wdin[15:0]}};
            end
            SZ_WORD: begin
                w_be    = 4'b1111;
                w_wdata = ram_wdin;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = ram_wdin;
            end
        endcase
    end

    // A faulted store must leave the RAM untouched.
    assign w_ram_we = w_accept && req_we && !w_fault;

    // ------------------------------------------------------------------
    // RAM: byte-lane write and synchronous read, both on acceptance
    // ------------------------------------------------------------------
    // Write lanes and capture read data; r_rdata holds while S1 stalls
    // because nothing is accepted then.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
        if (w_accept) begin
            r_rdata <= r_mem[w_idx];
        end
    end

    // ------------------------------------------------------------------
    // S1: request attributes travelling alongside the RAM read
    // ------------------------------------------------------------------
    // Load S1 on acceptance, empty it when it drains with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_we    <= 1'b0;
            r_s1_ext   <= 3'b000;
            r_s1_off   <= 2'b00;
            r_s1_fault <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= req_valid;
            if (req_valid) begin
                r_s1_tag   <= req_tag;
                r_s1_we    <= req_we;
                r_s1_ext   <= mem_ext_op;
                r_s1_off   <= w_lane;
                r_s1_fault <= w_fault;
            end
        end
    end

    // ------------------------------------------------------------------
    // load extraction and extension
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_dout_nxt;

    assign w_byte = r_rdata[{r_s1_off, 3'b000} +: 8];
    assign w_half = r_s1_off[1] ? r_rdata[31:16] : r_rdata[15:0];

    // Select the addressed byte/half/word and extend it per load type.
    always_comb begin
        w_load = 32'h0000_0000;
        case (r_s1_ext)
            EXT_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            EXT_LH:  w_load = {{16{w_half[15]}}, w_half};
            EXT_LW:  w_load = r_rdata;
            EXT_LBU: w_load = {24'h000000, w_byte};
            EXT_LHU: w_load = {16'h0000, w_half};
            default: w_load = 32'h0000_0000;
        endcase
    end

    // Stores and faulted accesses always return zero data.
    assign w_dout_nxt = (r_s1_we || r_s1_fault) ? 32'h0000_0000 : w_load;

    // ------------------------------------------------------------------
    // S2: response registers
    // ------------------------------------------------------------------
    // Move S1 into the output registers whenever the response slot is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid    <= 1'b0;
            r_dout          <= 32'h0000_0000;
            r_resp_tag      <= '0;
            r_resp_is_store <= 1'b0;
            r_resp_fault    <= 1'b0;
        end else if (w_adv2) begin
            r_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dout          <= w_dout_nxt;
                r_resp_tag      <= r_s1_tag;
                r_resp_is_store <= r_s1_we;
                r_resp_fault    <= r_s1_fault;
            end
        end
    end

    assign resp_valid    = r_resp_valid;
    assign mem_dout      = r_dout;
    assign resp_tag      = r_resp_tag;
    assign resp_is_store = r_resp_is_store;
    assign resp_fault    = r_resp_fault;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe: directed vector table, latency, backpressure,
// reset mid-flight and a randomized stream against a byte-array model.
module tb_mem_wb_pipe;

    localparam int ADDR_W      = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam int TAG_W       = 5;
    localparam longint BASE    = 0;
    localparam int EW          = 2 + TAG_W + 32;
    localparam int NV          = 31;

    // ------------------------------------------------------------------
    // clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] adr = '0;
    logic [1:0]        ram_w_op = 2'b10;
    logic [31:0]       ram_wdin = 32'h0;
    logic [2:0]        mem_ext_op = 3'b010;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [31:0]       mem_dout;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_is_store;
    logic              resp_fault;

    always #5 clk = ~clk;

    mem_wb_pipe #(
        .ADDR_W(ADDR_W),
        .DEPTH_WORDS(DEPTH_WORDS),
        .BASE_ADDR(32'h0),
        .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .adr(adr),
        .ram_w_op(ram_w_op),
        .ram_wdin(ram_wdin),
        .mem_ext_op(mem_ext_op),
        .req_tag(req_tag),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .mem_dout(mem_dout),
        .resp_tag(resp_tag),
        .resp_is_store(resp_is_store),
        .resp_fault(resp_fault)
    );

    // ------------------------------------------------------------------
    // bookkeeping
    // ------------------------------------------------------------------
    int n_cmp  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_resp = 0;
    int n_drop = 0;
    int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random

    logic [EW-1:0] exp_q[$];
    logic [7:0]    mdl_mem [4*DEPTH_WORDS];

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [1:0]  wop;
        logic [31:0] wd;
        logic [2:0]  ext;
        logic [31:0] dout;
        logic        flt;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input logic we, input logic [31:0] a,
                                input logic [1:0] wop, input logic [31:0] wd,
                                input logic [2:0] ext, input logic [31:0] dout,
                                input logic flt);
        vec_t v;
        v.we = we; v.a = a; v.wop = wop; v.wd = wd;
        v.ext = ext; v.dout = dout; v.flt = flt;
        return v;
    endfunction

    function automatic logic [EW-1:0] pack_resp();
        return {resp_is_store, resp_fault, resp_tag, mem_dout};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, size/alignment/range rules.
    function automatic logic [EW-1:0] model_access(input logic we, input logic [31:0] a,
                                                   input logic [1:0] wop, input logic [31:0] wd,
                                                   input logic [2:0] ext, input logic [TAG_W-1:0] tag);
        int          size;
        bit          legal;
        bit          sgn;
        bit          flt;
        longint      off;
        logic [31:0] val;
        if (we) begin
            legal = (wop != 2'b11);
            size  = 1 << wop;
            sgn   = 1'b0;
        end else begin
            legal = (ext == 3'd0) || (ext == 3'd1) || (ext == 3'd2) || (ext == 3'd4) || (ext == 3'd5);
            size  = 1 << ext[1:0];
            sgn   = !ext[2];
        end
        off = longint'(a) - BASE;
        flt = !legal || (off < 0) || (off + size > 4 * DEPTH_WORDS) || ((off % size) != 0);
        val = 32'h0;
        if (!flt) begin
            if (we) begin
                for (int k = 0; k < size; k++) mdl_mem[int'(off) + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < size; k++) val = val | (32'(mdl_mem[int'(off) + k]) << (8 * k));
                if (sgn && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
            end
        end
        return {we, flt, tag, val};
    endfunction

    // ------------------------------------------------------------------
    // driver tasks
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        case (rdy_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'b0;
            default: resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Present one request and hold it until accepted; returns at the accept edge.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] wop,
                          input logic [31:0] wd, input logic [2:0] ext, input logic [TAG_W-1:0] tag,
                          input logic use_tbl, input logic [EW-1:0] tbl_exp);
        logic          rdy;
        logic [EW-1:0] m;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; adr = a; ram_w_op = wop;
        ram_wdin = wd; mem_ext_op = ext; req_tag = tag;
        rdy = 1'b0;
        for (int w = 0; w < 200 && !rdy; w++) begin
            if (w > 0) @(negedge clk);
            #1;
            rdy = req_ready;
            @(posedge clk);
        end
        if (!rdy) begin
            n_cmp++; n_fail++;
            $display("FAIL req_accept_timeout: tag %0d not accepted, required acceptance within 200 cycles", tag);
        end else begin
            m = model_access(we, a, wop, wd, ext, tag);
            exp_q.push_back(use_tbl ? tbl_exp : m);
            n_acc++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic set_rdy(input int mode);
        @(posedge clk);
        rdy_mode = mode;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // ------------------------------------------------------------------
    // scoreboard: compare every consumed response with the queue head
    // ------------------------------------------------------------------
    always begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        @(negedge clk);
        #2;
        if (!rst && resp_valid && resp_ready) begin
            got = pack_resp();
            n_resp++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_resp: got %h, required no response", got);
            end else begin
                e = exp_q.pop_front();
                check("resp", 64'(got), 64'(e));
            end
        end
    end

    // ------------------------------------------------------------------
    // stimulus
    // ------------------------------------------------------------------
    initial begin
        logic          we;
        logic [31:0]   a;
        logic [1:0]    wop;
        logic [2:0]    ext;
        int            r;

        for (int i = 0; i < 4 * DEPTH_WORDS; i++) mdl_mem[i] = 8'h00;

        tbl[0]  = mk(1'b1, 32'h0000_0000, 2'd2, 32'h55AA55AA, 3'd2, 32'h0, 1'b0);
        tbl[1]  = mk(1'b1, 32'h0000_0010, 2'd2, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0);
        tbl[2]  = mk(1'b0, 32'h0000_0010, 2'd2, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0);
        tbl[3]  = mk(1'b1, 32'h0000_0010, 2'd2, 32'h80FF7F01, 3'd2, 32'h0, 1'b0);
        tbl[4]  = mk(1'b0, 32'h0000_0013, 2'd2, 32'h0, 3'd0, 32'hFFFFFF80, 1'b0);
        tbl[5]  = mk(1'b0, 32'h0000_0013, 2'd2, 32'h0, 3'd4, 32'h00000080, 1'b0);
        tbl[6]  = mk(1'b0, 32'h0000_0012, 2'd2, 32'h0, 3'd1, 32'hFFFF80FF, 1'b0);
        tbl[7]  = mk(1'b0, 32'h0000_0010, 2'd2, 32'h0, 3'd5, 32'h00007F01, 1'b0);
        tbl[8]  = mk(1'b1, 32'h0000_0011, 2'd0, 32'hFFFFFFAA, 3'd2, 32'h0, 1'b0);
        tbl[9]  = mk(1'b0, 32'h0000_0010, 2'd2, 32'h0, 3'd2, 32'h80FFAA01, 1'b0);
        tbl[10] = mk(1'b0, 32'h0000_0012, 2'd2, 32'h0, 3'd2, 32'h0, 1'b1);
        tbl[11] = mk(1'b0, 32'h0000_0011, 2'd2, 32'h0, 3'd1, 32'h0, 1'b1);
        tbl[12] = mk(1'b1, 32'h0000_1000, 2'd2, 32'h12345678, 3'd2, 32'h0, 1'b1);
        tbl[13] = mk(1'b1, 32'h0000_0011, 2'd1, 32'h00001234, 3'd2, 32'h0, 1'b1);
        tbl[14] = mk(1'b1, 32'h0000_0010, 2'd3, 32'h0, 3'd2, 32'h0, 1'b1);
        tbl[15] = mk(1'b0, 32'h0000_0010, 2'd2, 32'h0, 3'd2, 32'h80FFAA01, 1'b0);
        tbl[16] = mk(1'b0, 32'h0000_0000, 2'd2, 32'h0, 3'd2, 32'h55AA55AA, 1'b0);
        tbl[17] = mk(1'b0, 32'h0000_0010, 2'd2, 32'h0, 3'd3, 32'h0, 1'b1);
        tbl[18] = mk(1'b0, 32'h0000_0010, 2'd2, 32'h0, 3'd6, 32'h0, 1'b1);
        tbl[19] = mk(1'b0, 32'h0000_0010, 2'd2, 32'h0, 3'd7, 32'h0, 1'b1);
        tbl[20] = mk(1'b1, 32'h0000_0014, 2'd2, 32'h11223344, 3'd2, 32'h0, 1'b0);
        tbl[21] = mk(1'b1, 32'h0000_0016, 2'd1, 32'hFFFFBEEF, 3'd2, 32'h0, 1'b0);
        tbl[22] = mk(1'b0, 32'h0000_0014, 2'd2, 32'h0, 3'd2, 32'hBEEF3344, 1'b0);
        tbl[23] = mk(1'b0, 32'h0000_0016, 2'd2, 32'h0, 3'd5, 32'h0000BEEF, 1'b0);
        tbl[24] = mk(1'b0, 32'h0000_0014, 2'd2, 32'h0, 3'd1, 32'h00003344, 1'b0);
        tbl[25] = mk(1'b0, 32'h0000_0017, 2'd2, 32'h0, 3'd0, 32'hFFFFFFBE, 1'b0);
        tbl[26] = mk(1'b0, 32'h0000_0015, 2'd2, 32'h0, 3'd4, 32'h00000033, 1'b0);
        tbl[27] = mk(1'b0, 32'hFFFF_FFFC, 2'd2, 32'h0, 3'd2, 32'h0, 1'b1);
        tbl[28] = mk(1'b1, 32'h0000_0FFF, 2'd0, 32'h0000009C, 3'd2, 32'h0, 1'b0);
        tbl[29] = mk(1'b0, 32'h0000_0FFF, 2'd2, 32'h0, 3'd0, 32'hFFFFFF9C, 1'b0);
        tbl[30] = mk(1'b0, 32'h0000_1000, 2'd2, 32'h0, 3'd0, 32'h0, 1'b1);

        // reset state
        repeat (3) @(negedge clk);
        #2;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mem_dout", 64'(mem_dout), 64'd0);
        check("rst_resp_tag", 64'(resp_tag), 64'd0);
        check("rst_is_store", 64'(resp_is_store), 64'd0);
        check("rst_fault", 64'(resp_fault), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // directed table, back-to-back, always ready
        for (int i = 0; i < NV; i++) begin
            do_req(tbl[i].we, tbl[i].a, tbl[i].wop, tbl[i].wd, tbl[i].ext, TAG_W'(i), 1'b1,
                   {tbl[i].we, tbl[i].flt, TAG_W'(i), tbl[i].dout});
        end
        idle();
        drain();

        // latency: response visible one edge after the accept edge
        do_req(1'b0, 32'h10, 2'd2, 32'h0, 3'd2, 5'd7, 1'b1, {1'b0, 1'b0, 5'd7, 32'h80FFAA01});
        idle();
        #2;
        check("lat_not_yet", 64'(resp_valid), 64'd0);
        @(negedge clk);
        #2;
        check("lat_valid", 64'(resp_valid), 64'd1);
        check("lat_tag_data", 64'({resp_tag, mem_dout}), 64'({5'd7, 32'h80FFAA01}));
        drain();

        // backpressure: four loads while the response side is blocked
        begin
            int r0;
            r0 = n_resp;
            set_rdy(1);
            fork
                begin
                    do_req(1'b0, 32'h10, 2'd2, 32'h0, 3'd2, 5'd10, 1'b1, {1'b0, 1'b0, 5'd10, 32'h80FFAA01});
                    do_req(1'b0, 32'h14, 2'd2, 32'h0, 3'd1, 5'd11, 1'b1, {1'b0, 1'b0, 5'd11, 32'h00003344});
                    do_req(1'b0, 32'h17, 2'd2, 32'h0, 3'd4, 5'd12, 1'b1, {1'b0, 1'b0, 5'd12, 32'h000000BE});
                    do_req(1'b0, 32'h00, 2'd2, 32'h0, 3'd2, 5'd13, 1'b1, {1'b0, 1'b0, 5'd13, 32'h55AA55AA});
                end
                begin
                    int a0;
                    a0 = n_acc;
                    for (int c = 0; c < 6; c++) begin
                        @(negedge clk);
                        #2;
                        if (resp_valid && exp_q.size() > 0)
                            check("bp_hold", 64'(pack_resp()), 64'(exp_q[0]));
                    end
                    check("bp_accepts", 64'(n_acc - a0), 64'd2);
                    check("bp_req_ready", 64'(req_ready), 64'd0);
                    rdy_mode = 0;
                end
            join
            idle();
            drain();
            check("bp_resp_count", 64'(n_resp - r0), 64'd4);
        end

        // reset with both stages full
        do_req(1'b1, 32'h20, 2'd2, 32'hCAFEF00D, 3'd2, 5'd20, 1'b1, {1'b1, 1'b0, 5'd20, 32'h0});
        idle();
        drain();
        set_rdy(1);
        do_req(1'b0, 32'h20, 2'd2, 32'h0, 3'd2, 5'd21, 1'b1, {1'b0, 1'b0, 5'd21, 32'hCAFEF00D});
        do_req(1'b0, 32'h10, 2'd2, 32'h0, 3'd2, 5'd22, 1'b1, {1'b0, 1'b0, 5'd22, 32'h80FFAA01});
        idle();
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_resp_valid", 64'(resp_valid), 64'd0);
        check("rstmid_req_ready", 64'(req_ready), 64'd1);
        n_drop += exp_q.size();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_rdy(0);
        do_req(1'b0, 32'h20, 2'd2, 32'h0, 3'd2, 5'd23, 1'b1, {1'b0, 1'b0, 5'd23, 32'hCAFEF00D});
        idle();
        drain();

        // random stream: prefill a window, then mixed traffic with random resp_ready
        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 32'(4 * i), 2'd2, $urandom, 3'd2, TAG_W'($urandom), 1'b0, '0);
        end
        idle();
        drain();
        set_rdy(2);
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 15);
            if (r == 0)      a = 32'h1000 + $urandom_range(0, 255);
            else if (r == 1) a = $urandom | 32'h0001_0000;
            else             a = 32'($urandom_range(0, 63));
            wop = (($urandom_range(0, 7)) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 5))
                0: ext = 3'd0;
                1: ext = 3'd1;
                2: ext = 3'd2;
                3: ext = 3'd4;
                4: ext = 3'd5;
                default: ext = 3'($urandom_range(0, 7));
            endcase
            do_req(we, a, wop, $urandom, ext, TAG_W'($urandom), 1'b0, '0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        set_rdy(0);
        drain();

        check("resp_total", 64'(n_resp), 64'(n_acc - n_drop));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #1000000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
